gbus_xfer_ctrl: RTL and testbench

- Bus-ownership controller directly downstream of the gbus `arbiter`.
- Presents pending requester valids to the arbiter and captures the one-hot grant.
- Holds that ownership for the whole multi-beat transfer, muxing the owner's address/data/last onto the single global bus with valid/ready flow control.
- Releases ownership on the last beat, so the arbiter is only consulted between transfers.

---
 rtl/gbus_xfer_ctrl_pkg.sv | 28 ++
 rtl/gbus_src_mux.sv | 36 +++
 rtl/gbus_xfer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_gbus_xfer_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbus_xfer_ctrl_pkg.sv
// Shared gbus definitions: controller state encoding, default bus geometry
// and a one-hot to index helper.
package gbus_xfer_ctrl_pkg;

  localparam int REQ_NUM    = 8;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 64;
  localparam int ID_WIDTH   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  // Widest one-hot vector the index helper accepts.
  localparam int IDX_MAX = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // OR-reduction of the set bit positions; exact for a one-hot input.
  function automatic int unsigned onehot2idx(input logic [IDX_MAX-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < IDX_MAX; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/gbus_src_mux.sv
// Owner select for the gbus: AND-OR mux of the owning requester's
// valid/addr/data/last slices, steered by the one-hot owner vector.
// An all-zero select yields all-zero outputs.
module gbus_src_mux #(
  parameter int REQ_NUM    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic [REQ_NUM-1:0]            sel_oh_i,
  input  logic [REQ_NUM-1:0]            src_vld_i,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] src_addr_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] src_data_i,
  input  logic [REQ_NUM-1:0]            src_last_i,
  output logic                          vld_o,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          last_o
);

  // Select the owner's slices.
  always_comb begin
    vld_o  = 1'b0;
    last_o = 1'b0;
    addr_o = '0;
    data_o = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (sel_oh_i[i]) begin
        vld_o  = vld_o  | src_vld_i[i];
        last_o = last_o | src_last_i[i];
        addr_o = addr_o | src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_o = data_o | src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/gbus_xfer_ctrl.sv
// gbus transfer controller: sits behind the gbus arbiter, latches the grant
// and holds bus ownership for a whole multi-beat transfer, releasing on the
// last beat or after MAX_BURST beats.
// Optional owner-stall timeout: define GBUS_XFER_TIMEOUT_EN (adds TIMEOUT
// parameter and xfer_timeout output).
module gbus_xfer_ctrl #(
  parameter int                        REQ_NUM        = gbus_xfer_ctrl_pkg::REQ_NUM,
  parameter int                        ADDR_WIDTH     = gbus_xfer_ctrl_pkg::ADDR_WIDTH,
  parameter int                        DATA_WIDTH     = gbus_xfer_ctrl_pkg::DATA_WIDTH,
  parameter logic [REQ_NUM-1:0]        FIRST_PRIORITY = REQ_NUM'(1),
  parameter int                        MAX_BURST      = 16
`ifdef GBUS_XFER_TIMEOUT_EN
  , parameter int                      TIMEOUT        = 64
`endif
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [REQ_NUM-1:0]                           src_vld,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]                src_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]                src_data,
  input  logic [REQ_NUM-1:0]                           src_last,
  output logic [REQ_NUM-1:0]                           src_rdy,
  output logic [REQ_NUM-1:0]                           arb_req,
  output logic [REQ_NUM-1:0]                           arb_first_priority,
  input  logic [REQ_NUM-1:0]                           arb_grant,
  output logic                                         gbus_vld,
  output logic [ADDR_WIDTH-1:0]                        gbus_addr,
  output logic [DATA_WIDTH-1:0]                        gbus_data,
  output logic                                         gbus_last,
  output logic [((REQ_NUM > 1) ? $clog2(REQ_NUM) : 1)-1:0] gbus_src_id,
  input  logic                                         gbus_rdy,
  output logic                                         busy
`ifdef GBUS_XFER_TIMEOUT_EN
  , output logic                                       xfer_timeout
`endif
);

  import gbus_xfer_ctrl_pkg::*;

  localparam int ID_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_e              state_q, state_d;
  logic [REQ_NUM-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]     owner_id_q, owner_id_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IDX_MAX-1:0]  grant_ext;

  logic                mux_vld;
  logic                mux_last;
  logic                hs;
  logic                stall_release;

  gbus_src_mux #(
    .REQ_NUM    (REQ_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_src_mux (
    .sel_oh_i   (owner_q),
    .src_vld_i  (src_vld),
    .src_addr_i (src_addr),
    .src_data_i (src_data),
    .src_last_i (src_last),
    .vld_o      (mux_vld),
    .addr_o     (gbus_addr),
    .data_o     (gbus_data),
    .last_o     (mux_last)
  );

  // Only present requests while idle so the arbiter never rotates mid-transfer.
  assign arb_req            = (state_q == IDLE) ? src_vld : '0;
  assign arb_first_priority = FIRST_PRIORITY;
  assign busy               = (state_q == XFER);
  assign gbus_vld           = (state_q == XFER) & mux_vld;
  assign gbus_last          = mux_last;
  assign gbus_src_id        = owner_id_q;
  assign src_rdy            = owner_q & {REQ_NUM{gbus_rdy}};
  assign hs                 = gbus_vld & gbus_rdy;

`ifdef GBUS_XFER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_q, timeout_d;

  assign stall_release = (state_q == XFER) && !mux_vld &&
                         (idle_cnt_q == TO_W'(TIMEOUT - 1));
  assign xfer_timeout  = timeout_q;

  // Count consecutive owner-invalid cycles; any valid cycle or release clears.
  always_comb begin
    idle_cnt_d = '0;
    timeout_d  = stall_release;
    if ((state_q == XFER) && !mux_vld && !stall_release) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Stall counter and one-cycle timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  assign stall_release = 1'b0;
`endif

  // Ownership FSM next state: grab grant in IDLE, count beats and release in XFER.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_id_d = owner_id_q;
    beat_cnt_d = beat_cnt_q;
    grant_ext  = '0;
    grant_ext[REQ_NUM-1:0] = arb_grant;
    case (state_q)
      IDLE: begin
        if (|src_vld) begin
          state_d    = XFER;
          owner_d    = arb_grant;
          owner_id_d = ID_W'(onehot2idx(grant_ext));
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        if (hs) beat_cnt_d = beat_cnt_q + 1'b1;
        // Release on the requester's last beat or a forced split at MAX_BURST.
        if ((hs && (mux_last || (beat_cnt_q == LAST_CNT))) || stall_release) begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
    endcase
  end

  // Ownership FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_id_q <= owner_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    ((state_q == IDLE) && (|src_vld)) |-> $onehot(arb_grant));

  a_owner_onehot: assert property (@(posedge clk) disable iff (rst)
    (state_q == XFER) |-> $onehot(owner_q));

endmodule

// File: tb/tb_gbus_xfer_ctrl.sv
// Directed bench for gbus_xfer_ctrl with a fixed-priority arbiter model and
// a beat scoreboard filled in expected service order.
module tb_gbus_xfer_ctrl;

  localparam int N  = 8;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MB = 16;

  typedef struct {
    logic [2:0]    id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_vld;
  logic [N*AW-1:0] src_addr;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_last;
  logic [N-1:0]    src_rdy;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_first_priority;
  logic [N-1:0]    arb_grant;
  logic            gbus_vld;
  logic [AW-1:0]   gbus_addr;
  logic [DW-1:0]   gbus_data;
  logic            gbus_last;
  logic [2:0]      gbus_src_id;
  logic            gbus_rdy;
  logic            busy;
`ifdef GBUS_XFER_TIMEOUT_EN
  logic            xfer_timeout;
`endif

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  int unsigned rem[N];
  int unsigned k[N];
  bit          drop[N];
  bit          hs_now;

  always #5 clk = ~clk;

  // Fixed-priority arbiter: lowest requesting index wins.
  always_comb arb_grant = arb_req & (~arb_req + 1'b1);

  gbus_xfer_ctrl #(
    .REQ_NUM        (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FIRST_PRIORITY (8'h01),
    .MAX_BURST      (MB)
`ifdef GBUS_XFER_TIMEOUT_EN
    , .TIMEOUT      (4)
`endif
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .src_vld            (src_vld),
    .src_addr           (src_addr),
    .src_data           (src_data),
    .src_last           (src_last),
    .src_rdy            (src_rdy),
    .arb_req            (arb_req),
    .arb_first_priority (arb_first_priority),
    .arb_grant          (arb_grant),
    .gbus_vld           (gbus_vld),
    .gbus_addr          (gbus_addr),
    .gbus_data          (gbus_data),
    .gbus_last          (gbus_last),
    .gbus_src_id        (gbus_src_id),
    .gbus_rdy           (gbus_rdy),
    .busy               (busy)
`ifdef GBUS_XFER_TIMEOUT_EN
    , .xfer_timeout     (xfer_timeout)
`endif
  );

  function automatic logic [AW-1:0] f_addr(input int i, input int unsigned kk);
    return AW'((i << 12) | kk);
  endfunction

  function automatic logic [DW-1:0] f_data(input int i, input int unsigned kk);
    return {32'hC0DE0000 | 32'(i), (32'(kk) * 32'h01010101) ^ 32'(i * 7)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue a requester's transfer and push its beats as expected bus beats.
  task automatic start(input int i, input int unsigned n);
    beat_t e;
    rem[i] = n;
    k[i]   = 0;
    for (int unsigned b = 0; b < n; b++) begin
      e.id   = 3'(i);
      e.addr = f_addr(i, b);
      e.data = f_data(i, b);
      e.last = (b == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_vld[i]             = (rem[i] != 0) && !drop[i];
      src_addr[i*AW +: AW]   = f_addr(i, k[i]);
      src_data[i*DW +: DW]   = f_data(i, k[i]);
      src_last[i]            = (rem[i] == 1);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, score handshakes, advance requesters.
  task automatic step();
    beat_t e;
    @(negedge clk);
    drive();
    #1;
    hs_now = gbus_vld && gbus_rdy;
    if (hs_now) begin
      chk("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_id",   gbus_src_id, e.id);
        chk("beat_addr", gbus_addr,   e.addr);
        chk("beat_data", gbus_data,   e.data);
        chk("beat_last", gbus_last,   e.last);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (src_vld[i] && src_rdy[i]) begin
        k[i]++;
        rem[i]--;
      end
    end
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, (exp_q.size() == 0) && !busy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst      = 1'b1;
    gbus_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; k[i] = 0; drop[i] = 1'b0;
    end
    drive();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_vld", gbus_vld, 0);
    chk("rst_src_rdy", src_rdy, 0);
    chk("rst_arb_req", arb_req, 0);
    chk("rst_src_id", gbus_src_id, 0);
    chk("first_priority", arb_first_priority, 8'h01);
    @(negedge clk);
    rst = 1'b0;

    // Single requester 2, 3 beats.
    start(2, 3);
    step();
    chk("t1_arb_req", arb_req, 8'h04);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_vld", gbus_vld, 0);
    step();
    chk("t1_busy", busy, 1);
    chk("t1_arb_req_xfer", arb_req, 0);
    chk("t1_src_id", gbus_src_id, 2);
    chk("t1_hs", hs_now, 1);
    step();
    step();
    chk("t1_last", gbus_last, 1);
    step();
    chk("t1_busy_fall", busy, 0);
    chk("t1_vld_fall", gbus_vld, 0);
    chk("t1_sb_empty", exp_q.size() == 0, 1);

    // Requesters 0 and 5 contend; 0 wins, 5 follows after one IDLE cycle.
    start(0, 2);
    start(5, 2);
    step();
    chk("t2_arb_req", arb_req, 8'h21);
    step();
    chk("t2_owner0_id", gbus_src_id, 0);
    chk("t2_rdy_b1", src_rdy, 8'h01);
    step();
    chk("t2_rdy_b2", src_rdy, 8'h01);
    step();
    chk("t2_gap_busy", busy, 0);
    chk("t2_arb_req5", arb_req, 8'h20);
    step();
    chk("t2_owner5_id", gbus_src_id, 5);
    chk("t2_rdy5", src_rdy, 8'h20);
    drain("t2_drain", 10);

    // Backpressure: gbus_rdy 1,0,0,1 during a 4-beat burst from requester 3.
    start(3, 4);
    step();
    step();
    chk("t3_b1_hs", hs_now, 1);
    gbus_rdy = 1'b0;
    for (int r = 0; r < 2; r++) begin
      step();
      chk("t3_hold_vld", gbus_vld, 1);
      chk("t3_hold_rdy", src_rdy, 0);
      chk("t3_hold_addr", gbus_addr, f_addr(3, 1));
      chk("t3_hold_data", gbus_data, f_data(3, 1));
    end
    gbus_rdy = 1'b1;
    step();
    chk("t3_b2_hs", hs_now, 1);
    drain("t3_drain", 10);

    // 20-beat request: forced split after 16, one IDLE cycle, then 4 more.
    start(6, 20);
    step();
    chk("t4_arb_req", arb_req, 8'h40);
    nb = 0;
    repeat (16) begin
      step();
      nb += int'(hs_now);
    end
    chk("t4_first_beats", nb, 16);
    step();
    chk("t4_split_busy", busy, 0);
    chk("t4_split_vld", gbus_vld, 0);
    chk("t4_rereq", arb_req, 8'h40);
    step();
    chk("t4_regrant_id", gbus_src_id, 6);
    chk("t4_regrant_busy", busy, 1);
    drain("t4_drain", 10);
    chk("t4_rem", rem[6], 0);

    // Reset on beat 2 of 4; transfer restarts from beat 1.
    start(1, 4);
    step();
    step();
    chk("t5_b1_hs", hs_now, 1);
    @(negedge clk);
    drive();
    #1;
    chk("t5_pre_rst_vld", gbus_vld, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_vld", gbus_vld, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdy", src_rdy, 0);
    exp_q.delete();
    start(1, 4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("t5_rearb", arb_req, 8'h02);
    chk("t5_rearb_busy", busy, 0);
    step();
    chk("t5_restart_addr", gbus_addr, f_addr(1, 0));
    drain("t5_drain", 10);

`ifdef GBUS_XFER_TIMEOUT_EN
    // Owner stalls 4 cycles with TIMEOUT=4: single timeout pulse, back to IDLE.
    start(4, 3);
    step();
    step();
    chk("t6_b1_hs", hs_now, 1);
    drop[4] = 1'b1;
    repeat (4) begin
      step();
      chk("t6_stall_busy", busy, 1);
      chk("t6_stall_vld", gbus_vld, 0);
      chk("t6_stall_to", xfer_timeout, 0);
    end
    step();
    chk("t6_to_busy", busy, 0);
    chk("t6_to_pulse", xfer_timeout, 1);
    step();
    chk("t6_to_clear", xfer_timeout, 0);
    drop[4] = 1'b0;
    drain("t6_drain", 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
